rgb_led_pwm: RTL and testbench
==============================

# rgb_led_pwm

Drives the three active-low status LEDs of `CubeTop` (`LED_R_`, `LED_G_`, `LED_B_`) from 8-bit RGB duty values using glitch-free PWM. It sits directly upstream of the LED pins, between the top-level colour source (pattern or debug logic) and the pad outputs. Colours arrive over a valid/ready handshake and are buffered in a one-entry pending register. They take effect only on a PWM period boundary, so a colour change never produces a truncated or stretched pulse.

## Interface
- `PWM_BITS`, 8, duty/counter width; the period is 2^PWM_BITS−1 ticks.
- `PRESCALE_DIV`, 4, number of clocks per PWM tick; legal range ≥1.
- `clk` input 1: system clock, `OSC_CLK_IN` domain (12.5 MHz).
- `reset_` input 1: reset. One clock; reset is synchronous and active-low.
- `color_valid` input 1: colour offer.
- `color_ready` output 1: pending buffer empty; a transfer occurs on `color_valid && color_ready`.
- `color_r`, `color_g`, `color_b` input `PWM_BITS` each: duty per channel. 0 = off, 2^PWM_BITS−1 = always on.
- `led_r_`, `led_g_`, `led_b_` output 1: active-low LED drives, registered.

## Operation
- Prescaler `pre` counts 0..PRESCALE_DIV−1. `tick` is asserted when `pre == PRESCALE_DIV−1`.
- PWM counter `cnt` advances on `tick` through 0..2^PWM_BITS−2 and wraps to 0.
- `boundary` = `tick && cnt == 2^PWM_BITS−2`.
- State machine:
  - **OFF** (reset state): all LEDs off. When `pending_full` is set, copy pending to active, clear `pending_full`, clear `pre` and `cnt`, and go to RUN.
  - **RUN**: on `boundary && pending_full`, copy pending to active and clear `pending_full`. RUN never returns to OFF except through reset.
- Pending buffer:
  - An accept loads `pend_rgb` and sets `pending_full`.
  - `color_ready` is the registered value of `!pending_full`.
  - An accept and a boundary in the same cycle are never in conflict: an accept requires `pending_full == 0`, so a boundary in that cycle has nothing to transfer. The colour accepted in that cycle is applied at the *next* boundary.
- LED output: `led_x_ <= !(state == RUN && cnt < act_x)`. The output compares the pre-update `cnt`, which gives one cycle of latency.
- Duty arithmetic:
  - Unsigned compare of `PWM_BITS` width.
  - Duty d gives an on-time of exactly d·PRESCALE_DIV clocks per period of (2^PWM_BITS−1)·PRESCALE_DIV clocks.
  - Duty 255 is continuously low with no glitch at the wrap.
- Reset values: `led_r_ = led_g_ = led_b_ = 1`, `color_ready = 1`, state OFF, `pre = cnt = 0`, `pending_full = 0`, active duties 0.
- Reset asserted mid-period or with a pending colour:
  - Everything returns to the reset values on the next clock edge.
  - The pending colour is discarded.
  - LEDs are off from the first clock edge at which `reset_` is sampled low.

## Timing
- Accept in OFF at cycle T:
  - `pending_full` is set at T+1.
  - At T+2 the active colour is loaded, state is RUN, and `pre = cnt = 0`.
  - LEDs reflect the new duties from T+3.
- Accept in RUN: the new duty appears on the LEDs one clock after the first `boundary` following the accept.
- `color_ready` falls the cycle after an accept. It rises the cycle after the pending colour is transferred.
- Worst-case hold-off before `color_ready` rises again: one full period, 1020 clocks at the default parameters.

## Structure
- Shared `cube_pkg`:
  - `LED_PWM_BITS` and `LED_PRESCALE_DIV` constants.
  - An `rgb_t` packed struct (r, g, b of `PWM_BITS`).
  - A state enum with values `LED_OFF` and `LED_RUN`.
- Sub-module `pwm_tick_gen`: a prescaler plus wrapping counter that outputs `tick`, `cnt` and `boundary`.
- The handshake, buffers and output registers stay in `rgb_led_pwm`.
- `CubeTop` instantiates one `rgb_led_pwm` and connects its outputs straight to `LED_*_`.

## Test plan
Default parameters (period 1020 clocks).

- **Reset:** hold `reset_ = 0` for 5 clocks. All LEDs are 1, `color_ready = 1`, and LEDs stay 1 for 2000 clocks with no colour offered.
- **First colour:** offer (r = 128, g = 0, b = 255) in OFF.
  - `led_r_` is low for 512 clocks per 1020.
  - `led_g_` stays high.
  - `led_b_` is low continuously.
  - First low edge appears 3 clocks after the accept.
- **Mid-period change:** while running r = 10, offer r = 200 at period offset 300.
  - `color_ready` goes 0 on the next clock.
  - The current period keeps 40 low clocks.
  - The next period shows 800 low clocks.
  - `color_ready` returns to 1 right after the boundary.
- **Back-pressure:** hold `color_valid` high with a changing colour every cycle.
  - Exactly one accept per period.
  - The last accepted colour before each boundary is the one displayed.
  - No colour is lost while `color_ready = 0`.
- **Boundary-coincident accept:** offer a colour in the exact `boundary` cycle with pending empty. It is displayed starting one period later, not immediately.
- **Reset mid-operation:** assert `reset_` with a colour pending at period offset 700.
  - LEDs go high on the next edge.
  - After release, `color_ready = 1` and LEDs stay off until a new colour is accepted.

Source files
------------

// File: rtl/cube_pkg.sv
// cube_pkg: constants and types shared by the CubeTop status-LED path.
//   LED_PWM_BITS     duty/counter width of the status-LED PWM
//   LED_PRESCALE_DIV system clocks per PWM tick
//   rgb_t            one colour at the default duty width
//   led_state_t      rgb_led_pwm controller state
package cube_pkg;

  localparam int unsigned LED_PWM_BITS     = 8;
  localparam int unsigned LED_PRESCALE_DIV = 4;

  typedef struct packed {
    logic [LED_PWM_BITS-1:0] r;
    logic [LED_PWM_BITS-1:0] g;
    logic [LED_PWM_BITS-1:0] b;
  } rgb_t;

  typedef enum logic {
    LED_OFF = 1'b0,
    LED_RUN = 1'b1
  } led_state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler plus wrapping PWM period counter.
//   clk, reset_  system clock, synchronous active-low reset
//   clr          synchronous clear of prescaler and counter
//   tick         one-clock strobe every PRESCALE_DIV clocks
//   cnt          PWM position, 0 .. 2^PWM_BITS-2
//   boundary     tick on the last position of a period
module pwm_tick_gen
  import cube_pkg::*;
#(
  parameter int unsigned PWM_BITS     = LED_PWM_BITS,
  parameter int unsigned PRESCALE_DIV = LED_PRESCALE_DIV
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                clr,
  output logic                tick,
  output logic [PWM_BITS-1:0] cnt,
  output logic                boundary
);

  localparam int unsigned PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE_DIV - 1);
  // Period is 2^PWM_BITS-1 ticks so that the all-ones duty is always on.
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [PRE_W-1:0] pre;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_ || clr) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: glitch-free PWM drive of the three active-low status LEDs.
//   clk, reset_             system clock, synchronous active-low reset
//   color_valid/ready       colour handshake; ready means pending buffer empty
//   color_r/g/b             duty per channel (0 off, all-ones always on)
//   led_r_/led_g_/led_b_    registered active-low LED drives
// An accepted colour waits in a one-entry pending register and becomes
// active only on a period boundary (or immediately when leaving OFF).
module rgb_led_pwm
  import cube_pkg::*;
#(
  parameter int unsigned PWM_BITS     = LED_PWM_BITS,
  parameter int unsigned PRESCALE_DIV = LED_PRESCALE_DIV
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] color_r,
  input  logic [PWM_BITS-1:0] color_g,
  input  logic [PWM_BITS-1:0] color_b,
  output logic                led_r_,
  output logic                led_g_,
  output logic                led_b_
);

  // Same layout as rgb_t, but sized by this instance's PWM_BITS.
  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } duty_t;

  led_state_t          state_q, state_d;
  logic                pend_full_q, pend_full_d;
  duty_t               pend_q, pend_d;
  duty_t               act_q, act_d;
  logic                accept;
  logic                tick_unused;
  logic [PWM_BITS-1:0] cnt;
  logic                boundary;

  // Counters are held at zero while OFF, so entering RUN starts a fresh period.
  pwm_tick_gen #(
    .PWM_BITS     (PWM_BITS),
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset_   (reset_),
    .clr      (state_q == LED_OFF),
    .tick     (tick_unused),
    .cnt      (cnt),
    .boundary (boundary)
  );

  assign accept = color_valid && color_ready;

  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    act_d       = act_q;

    // An accept needs an empty buffer, so it never overlaps a transfer below.
    if (accept) begin
      pend_d      = '{r: color_r, g: color_g, b: color_b};
      pend_full_d = 1'b1;
    end

    unique case (state_q)
      LED_OFF: begin
        if (pend_full_q) begin
          act_d       = pend_q;
          pend_full_d = 1'b0;
          state_d     = LED_RUN;
        end
      end
      LED_RUN: begin
        if (boundary && pend_full_q) begin
          act_d       = pend_q;
          pend_full_d = 1'b0;
        end
      end
      default: state_d = LED_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q     <= LED_OFF;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
      color_ready <= 1'b1;
      led_r_      <= 1'b1;
      led_g_      <= 1'b1;
      led_b_      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      // Registered copy of the next buffer state keeps ready exactly equal
      // to !pend_full_q, so no second accept can overwrite a pending colour.
      color_ready <= !pend_full_d;
      // Compare against the current cnt/act: one clock of output latency.
      led_r_      <= !((state_q == LED_RUN) && (cnt < act_q.r));
      led_g_      <= !((state_q == LED_RUN) && (cnt < act_q.g));
      led_b_      <= !((state_q == LED_RUN) && (cnt < act_q.b));
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm: directed, table-driven check of rgb_led_pwm at default
// parameters (8-bit duty, prescale 4, 1020-clock period).
module tb_rgb_led_pwm;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       color_valid = 1'b0;
  logic [7:0] color_r = '0;
  logic [7:0] color_g = '0;
  logic [7:0] color_b = '0;
  logic       color_ready;
  logic       led_r_, led_g_, led_b_;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rgb_led_pwm #(
    .PWM_BITS     (8),
    .PRESCALE_DIV (4)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .color_r     (color_r),
    .color_g     (color_g),
    .color_b     (color_b),
    .led_r_      (led_r_),
    .led_g_      (led_g_),
    .led_b_      (led_b_)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       first_r;   // led_r_ two clocks after the accept edge
    int         lo_r, lo_g, lo_b;  // low clocks over two periods (2040)
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_ = 1'b0;
    color_valid = 1'b0;
    repeat (n) step();
    reset_ = 1'b1;
  endtask

  // Returns positioned just after the accept edge.
  task automatic offer(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input string name);
    int n;
    n = 0;
    color_r = r;
    color_g = g;
    color_b = b;
    color_valid = 1'b1;
    while (!color_ready && n < 2500) begin
      step();
      n++;
    end
    if (!color_ready) check({name, "_accept_timeout"}, 0, 1);
    step();
    color_valid = 1'b0;
    check({name, "_ready_fall"}, color_ready, 0);
  endtask

  function automatic logic [7:0] bp_r(input int off);
    return 8'(off * 37 + 11);
  endfunction

  function automatic logic [7:0] bp_g(input int off);
    return 8'(off * 13 + 200);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_r, lo_g, lo_b, rdy, w1r, w2r, w1g, w2g, lo0, lo1, lo2;

    vecs[0] = '{r: 8'd128, g: 8'd0,   b: 8'd255, first_r: 1'b0, lo_r: 1024, lo_g: 0,    lo_b: 2040};
    vecs[1] = '{r: 8'd1,   g: 8'd254, b: 8'd10,  first_r: 1'b0, lo_r: 8,    lo_g: 2032, lo_b: 80};
    vecs[2] = '{r: 8'd255, g: 8'd128, b: 8'd1,   first_r: 1'b0, lo_r: 2040, lo_g: 1024, lo_b: 8};
    vecs[3] = '{r: 8'd0,   g: 8'd200, b: 8'd64,  first_r: 1'b1, lo_r: 0,    lo_g: 1600, lo_b: 512};

    // Reset and idle.
    reset_ = 1'b0;
    repeat (5) step();
    check("rst_led_r", led_r_, 1);
    check("rst_led_g", led_g_, 1);
    check("rst_led_b", led_b_, 1);
    check("rst_ready", color_ready, 1);
    reset_ = 1'b1;
    lo_r = 0; rdy = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!led_r_ || !led_g_ || !led_b_) lo_r++;
      if (color_ready) rdy++;
    end
    check("idle_leds_low", lo_r, 0);
    check("idle_ready", rdy, 2000);

    // Table: first colour from OFF, latency and duty over two periods.
    foreach (vecs[k]) begin
      do_reset(3);
      offer(vecs[k].r, vecs[k].g, vecs[k].b, $sformatf("v%0d", k));
      step();
      check($sformatf("v%0d_led_r_early", k), led_r_, 1);
      check($sformatf("v%0d_ready_rise", k), color_ready, 1);
      step();
      check($sformatf("v%0d_first_low", k), led_r_, vecs[k].first_r);
      lo_r = 0; lo_g = 0; lo_b = 0;
      for (int i = 0; i < 2040; i++) begin
        if (!led_r_) lo_r++;
        if (!led_g_) lo_g++;
        if (!led_b_) lo_b++;
        step();
      end
      check($sformatf("v%0d_lo_r", k), lo_r, vecs[k].lo_r);
      check($sformatf("v%0d_lo_g", k), lo_g, vecs[k].lo_g);
      check($sformatf("v%0d_lo_b", k), lo_b, vecs[k].lo_b);
    end

    // Mid-period change: r 10 -> 200 offered at period offset 300.
    do_reset(2);
    offer(8'd10, 8'd0, 8'd0, "mid");
    step();
    lo1 = 0; lo2 = 0;
    for (int off = 1; off <= 2040; off++) begin
      step();
      if (off == 301) begin
        check("mid_ready_fall", color_ready, 0);
        color_valid = 1'b0;
      end
      if (off == 1019) check("mid_ready_held", color_ready, 0);
      if (off == 1020) check("mid_ready_rise", color_ready, 1);
      if (!led_r_) begin
        if (off <= 1020) lo1++;
        else lo2++;
      end
      if (off == 300) begin
        color_r = 8'd200;
        color_valid = 1'b1;
      end
    end
    check("mid_cur_period", lo1, 40);
    check("mid_next_period", lo2, 800);

    // Accept in the exact boundary cycle: applied one period later.
    do_reset(2);
    offer(8'd20, 8'd0, 8'd0, "bnd");
    step();
    lo0 = 0; lo1 = 0; lo2 = 0;
    for (int off = 1; off <= 3060; off++) begin
      step();
      if (!led_r_) begin
        if (off <= 1020) lo0++;
        else if (off <= 2040) lo1++;
        else lo2++;
      end
      if (off == 1019) begin
        check("bnd_ready_before", color_ready, 1);
        color_r = 8'd100;
        color_valid = 1'b1;
      end
      if (off == 1020) begin
        check("bnd_ready_fall", color_ready, 0);
        color_valid = 1'b0;
      end
      if (off == 2039) check("bnd_ready_held", color_ready, 0);
      if (off == 2040) check("bnd_ready_rise", color_ready, 1);
    end
    check("bnd_period0", lo0, 80);
    check("bnd_period1", lo1, 80);
    check("bnd_period2", lo2, 400);

    // Back-pressure: valid held high, colour changes every clock.
    do_reset(2);
    offer(8'd50, 8'd0, 8'd0, "bp");
    step();
    rdy = 0; w1r = 0; w2r = 0; w1g = 0; w2g = 0;
    for (int off = 0; off <= 3060; off++) begin
      if (off > 0) step();
      if (off <= 3059) begin
        color_r = bp_r(off);
        color_g = bp_g(off);
        color_valid = 1'b1;
        if (color_ready) rdy++;
      end else begin
        color_valid = 1'b0;
      end
      if (off >= 1021 && off <= 2040) begin
        if (!led_r_) w1r++;
        if (!led_g_) w1g++;
      end
      if (off >= 2041) begin
        if (!led_r_) w2r++;
        if (!led_g_) w2g++;
      end
    end
    check("bp_accepts", rdy, 3);
    check("bp_win1_r", w1r, 4 * int'(bp_r(0)));
    check("bp_win1_g", w1g, 4 * int'(bp_g(0)));
    check("bp_win2_r", w2r, 4 * int'(bp_r(1020)));
    check("bp_win2_g", w2g, 4 * int'(bp_g(1020)));

    // Reset mid-operation with a colour pending.
    do_reset(2);
    offer(8'd128, 8'd255, 8'd255, "rmo");
    step();
    for (int off = 1; off <= 700; off++) begin
      step();
      if (off == 600) begin
        color_r = 8'd1; color_g = 8'd1; color_b = 8'd1;
        color_valid = 1'b1;
      end
      if (off == 601) begin
        check("rmo_pending", color_ready, 0);
        color_valid = 1'b0;
      end
    end
    check("rmo_g_on_before", led_g_, 0);
    reset_ = 1'b0;
    step();
    check("rmo_led_r", led_r_, 1);
    check("rmo_led_g", led_g_, 1);
    check("rmo_led_b", led_b_, 1);
    check("rmo_ready", color_ready, 1);
    step();
    reset_ = 1'b1;
    lo_r = 0; rdy = 0;
    for (int i = 0; i < 2100; i++) begin
      step();
      if (!led_r_ || !led_g_ || !led_b_) lo_r++;
      if (color_ready) rdy++;
    end
    check("rmo_leds_stay_off", lo_r, 0);
    check("rmo_ready_after", rdy, 2100);
    offer(8'd255, 8'd0, 8'd0, "rmo_new");
    step();
    step();
    check("rmo_new_on", led_r_, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
